// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and pointer-width helper,
// common to the single- and dual-clock FIFOs.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one sync
// write port and one async read port.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered fill count,
// almost-full/empty flags and sticky error.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PTR_WIDTH = clog2(DEPTH),
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 4,
  parameter bit FWFT      = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic               full_o,
  output logic               almost_full_o,
  input  logic               rd_en_i,
  output logic [WIDTH-1:0]   rdata_o,
  output logic               empty_o,
  output logic               almost_empty_o,
  output logic [PTR_WIDTH:0] count_o,
  output logic               overflow_o,
  output logic               underflow_o,
  input  logic               clr_err_i,
  output logic               error_o
);

  localparam int PW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] ONE = PW'(1);
  localparam logic [PTR_WIDTH:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_CNT = PW'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] AE_CNT = PW'(AE_LEVEL);

  logic [PTR_WIDTH:0] wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0] wr_nxt, rd_nxt;
  logic [PTR_WIDTH:0] cnt_q, cnt_d;
  logic               full_q, af_q;
  logic               empty_q, ae_q;
  logic               ovf_q, udf_q, err_q;
  logic               wr_ok, rd_ok;
  logic               wr_rej, rd_rej;
  logic [WIDTH-1:0]   mem_rdata;

  assign wr_ok  = wr_en_i & ~full_q;
  assign rd_ok  = rd_en_i & ~empty_q;
  assign wr_rej = wr_en_i & full_q;
  assign rd_rej = rd_en_i & empty_q;

  // Occupancy is the wrap-aware pointer distance
  assign wr_nxt = wr_ok ? wr_ptr + ONE : wr_ptr;
  assign rd_nxt = rd_ok ? rd_ptr + ONE : rd_ptr;
  assign cnt_d  = wr_nxt - rd_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      af_q    <= (cnt_d >= AF_CNT);
      empty_q <= (cnt_d == '0);
      ae_q    <= (cnt_d <= AE_CNT);
      ovf_q   <= wr_rej;
      udf_q   <= rd_rej;
      // A fresh error outranks a clear
      err_q   <= wr_rej | rd_rej
               | (err_q & ~clr_err_i);
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_WIDTH)
  ) u_mem (
    .clk   (clk_i),
    .we    (wr_ok),
    .waddr (wr_ptr[PTR_WIDTH-1:0]),
    .wdata (wdata_i),
    .raddr (rd_ptr[PTR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  if (FWFT) begin : g_fwft
    assign rdata_o = empty_q ? '0 : mem_rdata;
  end else begin : g_reg
    logic [WIDTH-1:0] rdata_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rdata_q <= '0;
      else if (rd_ok) rdata_q <= mem_rdata;
    end
    assign rdata_o = rdata_q;
  end

  assign full_o         = full_q;
  assign almost_full_o  = af_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = ae_q;
  assign count_o        = cnt_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;
  assign error_o        = err_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: queue model plus
// directed vectors, registered and FWFT copies.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] wdata = 8'h00;

  logic       r_full, r_af, r_empty, r_ae;
  logic       r_ovf, r_udf, r_err;
  logic [7:0] r_rdata;
  logic [4:0] r_count;
  logic       f_full, f_af, f_empty, f_ae;
  logic       f_ovf, f_udf, f_err;
  logic [7:0] f_rdata;
  logic [4:0] f_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_rdata = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  bit         m_err = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .WIDTH(8), .DEPTH(16), .AF_LEVEL(12),
    .AE_LEVEL(4), .FWFT(1'b0)
  ) u_reg (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wdata_i(wdata),
    .full_o(r_full), .almost_full_o(r_af),
    .rd_en_i(rd_en), .rdata_o(r_rdata),
    .empty_o(r_empty), .almost_empty_o(r_ae),
    .count_o(r_count), .overflow_o(r_ovf),
    .underflow_o(r_udf), .clr_err_i(clr_err),
    .error_o(r_err)
  );

  sync_fifo_flags #(
    .WIDTH(8), .DEPTH(16), .AF_LEVEL(12),
    .AE_LEVEL(4), .FWFT(1'b1)
  ) u_fwft (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wdata_i(wdata),
    .full_o(f_full), .almost_full_o(f_af),
    .rd_en_i(rd_en), .rdata_o(f_rdata),
    .empty_o(f_empty), .almost_empty_o(f_ae),
    .count_o(f_count), .overflow_o(f_ovf),
    .underflow_o(f_udf), .clr_err_i(clr_err),
    .error_o(f_err)
  );

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rdata = 8'h00;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step();
    bit full, empty;
    full  = (m_q.size() == 16);
    empty = (m_q.size() == 0);
    m_ovf = wr_en && full;
    m_udf = rd_en && empty;
    if (rd_en && !empty) m_rdata = m_q.pop_front();
    if (wr_en && !full) m_q.push_back(wdata);
    m_err = m_ovf || m_udf || (m_err && !clr_err);
  endtask

  always @(negedge clk) begin
    int n;
    n = m_q.size();
    chk("count", int'(r_count), n);
    chk("full", int'(r_full), int'(n == 16));
    chk("afull", int'(r_af), int'(n >= 12));
    chk("empty", int'(r_empty), int'(n == 0));
    chk("aempty", int'(r_ae), int'(n <= 4));
    chk("ovf", int'(r_ovf), int'(m_ovf));
    chk("udf", int'(r_udf), int'(m_udf));
    chk("err", int'(r_err), int'(m_err));
    chk("rdata", int'(r_rdata), int'(m_rdata));
    chk("f_count", int'(f_count), n);
    chk("f_full", int'(f_full), int'(n == 16));
    chk("f_afull", int'(f_af), int'(n >= 12));
    chk("f_empty", int'(f_empty), int'(n == 0));
    chk("f_aempty", int'(f_ae), int'(n <= 4));
    chk("f_ovf", int'(f_ovf), int'(m_ovf));
    chk("f_udf", int'(f_udf), int'(m_udf));
    chk("f_err", int'(f_err), int'(m_err));
    if (n != 0)
      chk("f_head", int'(f_rdata), int'(m_q[0]));
  end

  task automatic cyc(input bit w, input bit r,
                     input logic [7:0] d, input bit c);
    wr_en = w;
    rd_en = r;
    wdata = d;
    clr_err = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_count", int'(r_count), 0);
    chk("rst_empty", int'(r_empty), 1);
    chk("rst_aempty", int'(r_ae), 1);
    chk("rst_rdata", int'(r_rdata), 0);
    chk("rst_err", int'(r_err), 0);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i + 1), 1'b0);
      if (i == 3) chk("ae_w4", int'(r_ae), 1);
      if (i == 4) chk("ae_w5", int'(r_ae), 0);
      if (i == 10) chk("af_w11", int'(r_af), 0);
      if (i == 11) chk("af_w12", int'(r_af), 1);
    end
    chk("fill_count", int'(r_count), 16);
    chk("fill_full", int'(r_full), 1);
    chk("fill_err", int'(r_err), 0);

    cyc(1'b1, 1'b0, 8'hAA, 1'b0);
    chk("ovf_pulse", int'(r_ovf), 1);
    chk("ovf_err", int'(r_err), 1);
    chk("ovf_count", int'(r_count), 16);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_once", int'(r_ovf), 0);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("rd_order", int'(r_rdata), i + 1);
    end
    chk("drain_empty", int'(r_empty), 1);

    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf_pulse", int'(r_udf), 1);
    chk("udf_rdata", int'(r_rdata), 8'h10);
    chk("udf_err", int'(r_err), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_err", int'(r_err), 0);

    for (int i = 0; i < 16; i++)
      cyc(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    cyc(1'b1, 1'b1, 8'hBB, 1'b0);
    chk("both_full_cnt", int'(r_count), 15);
    chk("both_full_ovf", int'(r_ovf), 1);
    chk("both_full_rd", int'(r_rdata), 8'h20);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (7) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("at8_count", int'(r_count), 8);
    for (int k = 0; k < 10; k++)
      cyc(1'b1, 1'b1, 8'(8'h40 + k), 1'b0);
    chk("both8_count", int'(r_count), 8);
    chk("both8_err", int'(r_err), 0);
    repeat (8) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain2_empty", int'(r_empty), 1);

    cyc(1'b1, 1'b0, 8'h5A, 1'b0);
    chk("fwft_empty", int'(f_empty), 0);
    chk("fwft_data", int'(f_rdata), 8'h5A);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("reg_5a", int'(r_rdata), 8'h5A);

    d = 8'h80;
    repeat (3) begin
      cyc(1'b1, 1'b0, d, 1'b0);
      d++;
    end
    for (int j = 0; j < 10; j++) begin
      repeat (3) begin
        cyc(1'b1, 1'b0, d, 1'b0);
        d++;
      end
      repeat (3) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    end
    repeat (7) begin
      cyc(1'b1, 1'b1, d, 1'b0);
      d++;
    end
    chk("burst_count", int'(r_count), 3);

    wr_en = 1'b1;
    wdata = 8'hEE;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_count", int'(r_count), 0);
    chk("mid_rst_empty", int'(r_empty), 1);
    chk("mid_rst_rdata", int'(r_rdata), 0);
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b0;
    cyc(1'b1, 1'b0, 8'h77, 1'b0);
    chk("post_rst_cnt", int'(r_count), 1);
    chk("post_rst_head", int'(f_rdata), 8'h77);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_rst_rd", int'(r_rdata), 8'h77);
    chk("post_rst_empty", int'(r_empty), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
